// File: rtl/qpsk_pkg.sv
// Shared types and constants for the QPSK dibit packer / UART transmitter.
// Optional even parity is selected with the UART_PARITY_EN macro.
package qpsk_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    localparam int DIBITS_PER_BYTE      = 4;
    localparam int UART_DATA_BITS       = 8;
    localparam int SYS_CLK_HZ           = 100_000_000;
    localparam int UART_BAUD            = 115_200;
    localparam int DEFAULT_CLKS_PER_BIT = SYS_CLK_HZ / UART_BAUD;

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/qpsk_byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO, depth 2**FIFO_AW.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module qpsk_byte_fifo #(
    parameter int FIFO_AW = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [7:0]       push_data,
    input  logic             pop,
    output logic [7:0]       pop_data,
    output logic             full,
    output logic             empty,
    output logic [FIFO_AW:0] level
);

    localparam int DEPTH = 2 ** FIFO_AW;

    logic [7:0]       mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign level    = wr_ptr - rd_ptr;
    assign full     = (level == (FIFO_AW + 1)'(DEPTH));
    assign empty    = (level == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[FIFO_AW-1:0]];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[FIFO_AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/qpsk_dibit_uart_tx.sv
// Packs demodulated dibits into bytes, queues them and sends them as UART 8N1
// (8E1 when UART_PARITY_EN is defined) on uart_txd.
module qpsk_dibit_uart_tx
    import qpsk_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_AW      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       dibit_in,
    input  logic             dibit_valid,
    input  logic             symbol_lock,
    input  logic             error_flag,
    input  logic             ovf_clr,
    output logic             uart_txd,
    output logic             tx_busy,
    output logic [FIFO_AW:0] fifo_level,
    output logic             overflow
);

    localparam int                BAUD_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        LAST_IDX  = 3'(UART_DATA_BITS - 1);
    localparam logic [1:0]        LAST_DIB  = 2'(DIBITS_PER_BYTE - 1);

    // ---------------- dibit packer ----------------
    logic [1:0] pack_cnt;
    logic [7:0] pack_shift;
    logic       accept;
    logic       byte_done;
    logic [7:0] push_data;

    assign accept    = dibit_valid && symbol_lock && !error_flag;
    assign byte_done = accept && (pack_cnt == LAST_DIB);
    assign push_data = {pack_shift[5:0], dibit_in};

    // Loss of lock or a flagged dibit realigns the packer to a byte boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_cnt   <= '0;
            pack_shift <= '0;
        end else if (!symbol_lock || (dibit_valid && error_flag)) begin
            pack_cnt <= '0;
        end else if (accept) begin
            pack_shift <= push_data;
            pack_cnt   <= byte_done ? '0 : pack_cnt + 1'b1;
        end
    end

    // ---------------- byte FIFO ----------------
    logic       fifo_pop;
    logic [7:0] fifo_dout;
    logic       fifo_full;
    logic       fifo_empty;

    qpsk_byte_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (byte_done),
        .push_data (push_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              overflow <= 1'b0;
        else if (byte_done && fifo_full && !fifo_pop) overflow <= 1'b1;
        else if (ovf_clr)                        overflow <= 1'b0;
    end

    // ---------------- UART transmitter ----------------
    tx_state_t         state, state_nx;
    logic [BAUD_W-1:0] baud_cnt, baud_nx;
    logic [2:0]        bit_idx, idx_nx;
    logic [2:0]        idx_inc;
    logic [7:0]        tx_byte, byte_nx;
    logic              txd_q, txd_nx;
    logic              bit_end;

    assign bit_end  = (baud_cnt == BAUD_LAST);
    assign idx_inc  = bit_idx + 3'd1;
    assign uart_txd = txd_q;
    assign tx_busy  = (state != TX_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= TX_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_byte  <= '0;
            txd_q    <= 1'b1;
        end else begin
            state    <= state_nx;
            baud_cnt <= baud_nx;
            bit_idx  <= idx_nx;
            tx_byte  <= byte_nx;
            txd_q    <= txd_nx;
        end
    end

    // txd_nx is the line level of the cycle being entered, so the pin is a plain flop.
    // NOTE: every always_comb output gets a default first, which rules out inferred latches.
    always_comb begin
        state_nx = state;
        baud_nx  = baud_cnt + BAUD_W'(1);
        idx_nx   = bit_idx;
        byte_nx  = tx_byte;
        txd_nx   = txd_q;
        fifo_pop = 1'b0;
        case (state)
            TX_IDLE: begin
                baud_nx = '0;
                txd_nx  = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    byte_nx  = fifo_dout;
                    state_nx = TX_START;
                    txd_nx   = 1'b0;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    baud_nx  = '0;
                    idx_nx   = '0;
                    state_nx = TX_DATA;
                    txd_nx   = tx_byte[0];
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    baud_nx = '0;
                    if (bit_idx == LAST_IDX) begin
`ifdef UART_PARITY_EN
                        state_nx = TX_PARITY;
                        txd_nx   = even_parity(tx_byte);
`else
                        state_nx = TX_STOP;
                        txd_nx   = 1'b1;
`endif
                    end else begin
                        idx_nx = idx_inc;
                        txd_nx = tx_byte[idx_inc];
                    end
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                if (bit_end) begin
                    baud_nx  = '0;
                    state_nx = TX_STOP;
                    txd_nx   = 1'b1;
                end
            end
`endif
            TX_STOP: begin
                if (bit_end) begin
                    baud_nx = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        byte_nx  = fifo_dout;
                        state_nx = TX_START;
                        txd_nx   = 1'b0;
                    end else begin
                        state_nx = TX_IDLE;
                        txd_nx   = 1'b1;
                    end
                end
            end
            default: begin
                baud_nx  = '0;
                state_nx = TX_IDLE;
                txd_nx   = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_qpsk_dibit_uart_tx.sv
// Scoreboard bench: the stimulus side models the packer and queues expected bytes,
// a UART line monitor decodes frames from uart_txd and compares them.
module tb_qpsk_dibit_uart_tx;

    localparam int CPB = 4;
    localparam int AW  = 2;
`ifdef UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    dibit_in;
    logic          dibit_valid;
    logic          symbol_lock;
    logic          error_flag;
    logic          ovf_clr;
    logic          uart_txd;
    logic          tx_busy;
    logic [AW:0]   fifo_level;
    logic          overflow;

    qpsk_dibit_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dibit_in    (dibit_in),
        .dibit_valid (dibit_valid),
        .symbol_lock (symbol_lock),
        .error_flag  (error_flag),
        .ovf_clr     (ovf_clr),
        .uart_txd    (uart_txd),
        .tx_busy     (tx_busy),
        .fifo_level  (fifo_level),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         pass_cnt = 0;
    int         chk_cnt  = 0;
    logic [7:0] exp_q[$];
    logic [1:0] pend[$];
    int         start_q[$];
    bit         mon_busy = 0;
    bit         completed;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference packer: collect accepted dibits in time order, four make a byte.
    task automatic drive(input logic v, input logic [1:0] d, input logic lk, input logic er,
                         input bit keep = 1'b1);
        logic [7:0] b;
        dibit_valid = v;
        dibit_in    = d;
        symbol_lock = lk;
        error_flag  = er;
        completed   = 1'b0;
        if (!lk || (v && er)) begin
            pend.delete();
        end else if (v) begin
            pend.push_back(d);
            if (pend.size() == 4) begin
                b = 8'(pend[0] * 64 + pend[1] * 16 + pend[2] * 4 + pend[3]);
                if (keep) exp_q.push_back(b);
                pend.delete();
                completed = 1'b1;
            end
        end
        @(negedge clk);
        dibit_valid = 1'b0;
        symbol_lock = 1'b1;
        error_flag  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit keep = 1'b1);
        for (int k = 3; k >= 0; k--) drive(1'b1, b[2*k +: 2], 1'b1, 1'b0, keep);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", n < 5000, 1);
        repeat (3) @(negedge clk);
    endtask

    // ---------------- line monitor ----------------
    task automatic wait_neg(input int n, output bit ok);
        ok = 1'b1;
        repeat (n) begin
            @(negedge clk);
            if (!rst_n) ok = 1'b0;
        end
    endtask

    task automatic decode_frame();
        logic [7:0] b;
        logic       par;
        logic [7:0] e;
        bit         ok;
        mon_busy = 1'b1;
        start_q.push_back(cyc);
        par = 1'b0;
        wait_neg(CPB / 2, ok);
        if (!ok) begin mon_busy = 1'b0; return; end
        check("frame_start_bit", uart_txd, 0);
        for (int i = 0; i < 8; i++) begin
            wait_neg(CPB, ok);
            if (!ok) begin mon_busy = 1'b0; return; end
            b[i] = uart_txd;
        end
`ifdef UART_PARITY_EN
        wait_neg(CPB, ok);
        if (!ok) begin mon_busy = 1'b0; return; end
        par = uart_txd;
`endif
        wait_neg(CPB, ok);
        if (!ok) begin mon_busy = 1'b0; return; end
        check("frame_stop_bit", uart_txd, 1);
        check("frame_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("frame_byte", b, e);
`ifdef UART_PARITY_EN
            check("frame_parity", par, ^e);
`endif
        end
        wait_neg(CPB - CPB / 2 - 1, ok);
        mon_busy = 1'b0;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n && uart_txd === 1'b0) decode_frame();
        end
    end

    initial begin : watchdog
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int         busy_cyc;
        logic [7:0] burst [6];

        rst_n       = 1'b0;
        dibit_in    = '0;
        dibit_valid = 1'b0;
        symbol_lock = 1'b1;
        error_flag  = 1'b0;
        ovf_clr     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_txd", uart_txd, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_level", fifo_level, 0);
        check("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 00,01,11,10 -> 0x1E with latency and frame-length checks
        drive(1, 2'b00, 1, 0);
        drive(1, 2'b01, 1, 0);
        drive(1, 2'b11, 1, 0);
        drive(1, 2'b10, 1, 0);
        check("lat_level_n1", fifo_level, 1);
        check("lat_txd_n1", uart_txd, 1);
        @(negedge clk);
        check("lat_txd_n2", uart_txd, 0);
        check("lat_busy_n2", tx_busy, 1);
        check("lat_level_n2", fifo_level, 0);
        busy_cyc = 1;
        while (busy_cyc < 500) begin
            @(negedge clk);
            if (!tx_busy) break;
            busy_cyc++;
        end
        check("busy_cycles", busy_cyc, FRAME_CYC);
        wait_drain();

        send_byte(8'h1F);
        wait_drain();

        // Partial byte dropped by loss of lock
        drive(1, 2'b10, 1, 0);
        drive(1, 2'b01, 1, 0);
        drive(0, 2'b00, 0, 0);
        for (int k = 0; k < 4; k++) drive(1, 2'b11, 1, 0);
        wait_drain();

        // Error-flagged dibit resyncs the packer
        drive(1, 2'b11, 1, 0);
        drive(1, 2'b01, 1, 1);
        for (int k = 0; k < 4; k++) drive(1, 2'b10, 1, 0);
        wait_drain();

        // Overflow burst: six bytes back to back, the sixth finds the FIFO full
        for (int k = 0; k < 6; k++) burst[k] = 8'($urandom);
        start_q.delete();
        for (int k = 0; k < 6; k++) send_byte(burst[k], k < 5);
        check("ovf_level", fifo_level, 4);
        check("ovf_set", overflow, 1);
        repeat (3) @(negedge clk);
        check("ovf_sticky", overflow, 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_cleared", overflow, 0);
        wait_drain();
        check("b2b_frames", start_q.size(), 5);
        for (int k = 1; k < start_q.size(); k++)
            check("b2b_gap", start_q[k] - start_q[k-1], FRAME_CYC);

        // Reset in the middle of DATA with a second byte queued
        send_byte(8'h5A);
        send_byte(8'hC3);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        pend.delete();
        #1;
        check("midrst_txd", uart_txd, 1);
        check("midrst_busy", tx_busy, 0);
        check("midrst_level", fifo_level, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send_byte(8'h96);
        wait_drain();

        // Randomised dibit stream with lock drops and errors
        for (int s = 0; s < 160; s++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 11) != 0, $urandom_range(0, 11) == 0);
            if (completed) repeat (FRAME_CYC + 4) @(negedge clk);
        end
        wait_drain();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/qpsk_dibit_uart_tx.md
Name: qpsk_dibit_uart_tx

Overview:
Downstream stage of the QPSK demodulator. Consumes the demodulated 2-bit symbols (bit_output/bit_valid with symbol_lock and error_flag) and packs four dibits into a byte. Completed bytes go into a small synchronous FIFO, and the block serialises them as UART 8N1 on uart_txd toward the host. Sits between the demodulator core and the top-level uart_txd pin.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud); minimum 2.
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW bytes.

Ports:
clk  input  1  system clock (100 MHz)
rst_n  input  1  asynchronous active-low reset
dibit_in  input  2  demodulated symbol bits, MSB first in time order
dibit_valid  input  1  one-cycle strobe qualifying dibit_in
symbol_lock  input  1  demodulator lock indicator
error_flag  input  1  demodulator error for the current dibit
ovf_clr  input  1  clears the sticky overflow flag
uart_txd  output  1  serial output, idle high
tx_busy  output  1  high whenever the TX FSM is not IDLE
fifo_level  output  FIFO_AW+1  number of bytes queued
overflow  output  1  sticky; set when a byte is dropped because the FIFO is full

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: uart_txd=1, tx_busy=0, fifo_level=0, overflow=0. Packer count=0, shift register=0, FSM=IDLE.
- Reset takes effect immediately, including mid-frame. uart_txd returns high asynchronously and any queued and partial data is lost.
- Packer accepts a dibit when dibit_valid && symbol_lock && !error_flag: shift={shift[5:0],dibit_in}, count+1. The first dibit lands in bits [7:6].
- On the 4th accepted dibit, the byte {shift[5:0],dibit_in} is pushed to the FIFO on the next clock edge and count wraps to 0.
- symbol_lock=0 at any cycle clears count (partial byte discarded).
- dibit_valid with error_flag=1 discards the dibit and clears count (resync to byte boundary).
- FIFO push while full: byte dropped, overflow set. overflow stays set until ovf_clr=1; if ovf_clr and a new drop occur in the same cycle, set wins.
- Simultaneous push and pop when full: both happen and the level is unchanged.
- Pop is issued only by the TX FSM and only when fifo_level>0.
- TX FSM states and transitions:
  - IDLE: txd=1. If FIFO not empty: pop, load the byte into the TX shift register, go to START.
  - START: txd=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each; a 3-bit index counts 0..7.
  - PARITY (macro only): see Optional Feature.
  - STOP: txd=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is not empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1, resets on every state or bit change, and has width $clog2(CLKS_PER_BIT).
- uart_txd is registered (glitch-free).
- Latency: 4th dibit strobe at cycle N → FIFO holds the byte at N+1 → popped at N+1 edge when idle → txd low from N+2. The frame lasts 10*CLKS_PER_BIT cycles.
- tx_busy=1 from the START entry through the last STOP cycle; it stays high across back-to-back frames.

Optional Feature:
- Macro UART_PARITY_EN.
- Defined: a PARITY state between DATA and STOP sends the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. The frame becomes 11 bits.
- Undefined: no PARITY state; 8N1 framing, 10 bits per frame.

Decomposition:
- Package qpsk_pkg: TX FSM state encoding (IDLE, START, DATA, PARITY, STOP), DIBITS_PER_BYTE=4, UART_DATA_BITS=8, default baud constants.
- One sub-module: qpsk_byte_fifo. Synchronous FWFT FIFO, parameter FIFO_AW, with push/pop/full/empty/level; same clk/rst_n.
- Packer and TX FSM stay in the top module.

Test Plan (CLKS_PER_BIT=4, FIFO_AW=2):
- Reset, then dibits 00,01,11,10 with lock=1 → byte 0x1E. txd frame: 0, then bits 0,1,1,1,1,0,0,0, then 1, each bit 4 cycles. tx_busy high for 40 cycles.
- Two dibits, drop symbol_lock one cycle, then 11,11,11,11 → only 0xFF transmitted; the partial byte is discarded.
- Dibit 01 with error_flag=1 mid-byte → count clears. The next 4 clean dibits 10,10,10,10 form 0xAA.
- Push 6 bytes back-to-back while TX is stalled by an ongoing frame → fifo_level saturates at 4 and overflow=1. Five bytes transmit with no idle gap between frames. ovf_clr → overflow=0.
- Assert rst_n=0 in the middle of the DATA state → uart_txd=1 immediately, fifo_level=0, tx_busy=0. The next frame after reset release is correct.
- With UART_PARITY_EN, byte 0x1E → parity bit 0 and an 11-bit frame. Byte 0x1F → parity bit 1.
